// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the async FIFO write- and read-side blocks.
// The Gray conversions work on a 32-bit container; zero-extend narrower pointers on the way in.
package fifo_pkg;

  localparam int DEF_ADDR_SIZE = 4;
  localparam int DEPTH         = 1 << DEF_ADDR_SIZE;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero upper bits pass through the prefix unchanged, so any width <= 32 converts correctly.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray_to_bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[WIDTH-1:i];
  end

endmodule

// File: rtl/w_ptr_full_level.sv
// Write-side pointer/flag block of the async FIFO: binary and Gray write pointers,
// full, almost-full, fill level and sticky overflow, all in the write clock domain.
module w_ptr_full_level
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE = fifo_pkg::DEF_ADDR_SIZE
) (
  input  logic                 w_clk,
  input  logic                 w_rst,
  input  logic [ADDR_SIZE:0]   w_syn_r_gray,
  input  logic                 w_inc,
  input  logic [ADDR_SIZE:0]   w_afull_thresh,
  input  logic                 w_ovf_clr,
  output logic                 w_accept,
  output logic [ADDR_SIZE-1:0] w_addr,
  output logic [ADDR_SIZE:0]   w_gray,
  output logic                 w_full,
  output logic                 w_afull,
  output logic [ADDR_SIZE:0]   w_level,
  output logic                 w_ovf
);

  localparam int             PW      = ADDR_SIZE + 1;
  localparam logic [PW-1:0]  DEPTH_C = PW'(1) << ADDR_SIZE;

  logic [PW-1:0] w_bin_q,   w_bin_d;
  logic [PW-1:0] w_gray_q,  w_gray_d;
  logic [PW-1:0] w_level_q, w_level_d;
  logic          w_full_q,  w_full_d;
  logic          w_afull_q, w_afull_d;
  logic          w_ovf_q,   w_ovf_d;

  logic [PW-1:0] r_bin;
  logic [PW-1:0] thresh_c;

  gray_to_bin #(.WIDTH(PW)) u_r_gray_to_bin (
    .gray_i (w_syn_r_gray),
    .bin_o  (r_bin)
  );

  // A write in the reset cycle is dropped along with the rest of the pointer state.
  assign w_accept = w_inc & ~w_full_q & ~w_rst;

  assign thresh_c = (w_afull_thresh > DEPTH_C) ? DEPTH_C : w_afull_thresh;

  always_comb begin
    w_bin_d   = w_bin_q + PW'(w_accept);
    w_gray_d  = PW'(bin2gray(32'(w_bin_d)));
    // Full: next Gray pointer is the read Gray pointer with its two MSbs inverted.
    w_full_d  = (w_gray_d == {~w_syn_r_gray[PW-1:PW-2], w_syn_r_gray[PW-3:0]});
    // Modular subtract; the synced read pointer lags, so this only ever over-reports.
    w_level_d = w_bin_d - r_bin;
    w_afull_d = (w_afull_thresh != '0) && (w_level_d >= thresh_c);
    w_ovf_d   = (w_inc & w_full_q) | (w_ovf_q & ~w_ovf_clr);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      w_bin_q   <= '0;
      w_gray_q  <= '0;
      w_level_q <= '0;
      w_full_q  <= 1'b0;
      w_afull_q <= 1'b0;
      w_ovf_q   <= 1'b0;
    end else begin
      w_bin_q   <= w_bin_d;
      w_gray_q  <= w_gray_d;
      w_level_q <= w_level_d;
      w_full_q  <= w_full_d;
      w_afull_q <= w_afull_d;
      w_ovf_q   <= w_ovf_d;
    end
  end

  assign w_addr  = w_bin_q[ADDR_SIZE-1:0];
  assign w_gray  = w_gray_q;
  assign w_full  = w_full_q;
  assign w_afull = w_afull_q;
  assign w_level = w_level_q;
  assign w_ovf   = w_ovf_q;

endmodule

// File: tb/tb_w_ptr_full_level.sv
// Self-checking bench for w_ptr_full_level (ADDR_SIZE=4): a directed vector table
// followed by hand-written sequences for the rollover walk and mid-burst reset.
module tb_w_ptr_full_level;

  logic       w_clk = 1'b0;
  logic       w_rst;
  logic [4:0] w_syn_r_gray;
  logic       w_inc;
  logic [4:0] w_afull_thresh;
  logic       w_ovf_clr;
  logic       w_accept;
  logic [3:0] w_addr;
  logic [4:0] w_gray;
  logic       w_full;
  logic       w_afull;
  logic [4:0] w_level;
  logic       w_ovf;

  int total = 0;
  int bad   = 0;

  always #5 w_clk = ~w_clk;

  w_ptr_full_level #(.ADDR_SIZE(4)) dut (
    .w_clk          (w_clk),
    .w_rst          (w_rst),
    .w_syn_r_gray   (w_syn_r_gray),
    .w_inc          (w_inc),
    .w_afull_thresh (w_afull_thresh),
    .w_ovf_clr      (w_ovf_clr),
    .w_accept       (w_accept),
    .w_addr         (w_addr),
    .w_gray         (w_gray),
    .w_full         (w_full),
    .w_afull        (w_afull),
    .w_level        (w_level),
    .w_ovf          (w_ovf)
  );

  typedef struct {
    logic       rst;
    logic       inc;
    logic       clr;
    logic [4:0] rg;
    logic [4:0] thresh;
    logic       exp_accept;
    logic [3:0] exp_addr;
    logic [4:0] exp_gray;
    logic       exp_full;
    logic       exp_afull;
    logic [4:0] exp_level;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[64];
  int   n_vecs = 0;

  function automatic logic [4:0] g5(input int k);
    int m;
    m = k % 32;
    return 5'(m ^ (m >> 1));
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic inc, input logic clr, input logic [4:0] rg,
                     input logic [4:0] thresh, input logic acc, input int addr, input int gray,
                     input logic full, input logic afull, input int level, input logic ovf);
    vecs[n_vecs].rst        = rst;
    vecs[n_vecs].inc        = inc;
    vecs[n_vecs].clr        = clr;
    vecs[n_vecs].rg         = rg;
    vecs[n_vecs].thresh     = thresh;
    vecs[n_vecs].exp_accept = acc;
    vecs[n_vecs].exp_addr   = 4'(addr);
    vecs[n_vecs].exp_gray   = 5'(gray);
    vecs[n_vecs].exp_full   = full;
    vecs[n_vecs].exp_afull  = afull;
    vecs[n_vecs].exp_level  = 5'(level);
    vecs[n_vecs].exp_ovf    = ovf;
    n_vecs++;
  endtask

  task automatic drive(input logic rst, input logic inc, input logic clr,
                       input logic [4:0] rg, input logic [4:0] thresh);
    w_rst          = rst;
    w_inc          = inc;
    w_ovf_clr      = clr;
    w_syn_r_gray   = rg;
    w_afull_thresh = thresh;
  endtask

  task automatic check_all_zero(input string name, input int idx);
    check({name, "_addr"},  idx, 32'(w_addr),  0);
    check({name, "_gray"},  idx, 32'(w_gray),  0);
    check({name, "_full"},  idx, 32'(w_full),  0);
    check({name, "_afull"}, idx, 32'(w_afull), 0);
    check({name, "_level"}, idx, 32'(w_level), 0);
    check({name, "_ovf"},   idx, 32'(w_ovf),   0);
  endtask

  initial begin
    int wc;
    int rc;
    logic [4:0] prev_gray;

    // Reset held two cycles with a write request pending.
    add(1, 1, 0, 5'd0, 5'd12, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 5'd0, 5'd12, 0, 0, 0, 0, 0, 0, 0);
    // Fill with the read pointer parked at 0; almost-full rises at level 12.
    for (int k = 1; k <= 16; k++)
      add(0, 1, 0, 5'd0, 5'd12, 1, k % 16, g5(k), k == 16, k >= 12, k, 0);
    // Write while full: rejected, overflow sets next cycle.
    add(0, 1, 0, 5'd0,  5'd12, 0, 0, 5'b11000, 1, 1, 16, 1);
    // Set and clear together: set wins.
    add(0, 1, 1, 5'd0,  5'd12, 0, 0, 5'b11000, 1, 1, 16, 1);
    add(0, 0, 1, 5'd0,  5'd12, 0, 0, 5'b11000, 1, 1, 16, 0);
    // Reader advances to bin 5 (Gray 00111).
    add(0, 0, 0, 5'b00111, 5'd12, 0, 0, 5'b11000, 0, 0, 11, 0);
    add(0, 1, 0, 5'b00111, 5'd12, 1, 1, 5'b11001, 0, 1, 12, 0);
    // Threshold 0 disables almost-full.
    add(0, 0, 0, 5'b00111, 5'd0,  0, 1, 5'b11001, 0, 0, 12, 0);
    // Threshold above depth clamps to 16: asserts only when level reaches 16.
    add(0, 1, 0, 5'b00111, 5'd20, 1, 2, g5(18), 0, 0, 13, 0);
    add(0, 1, 0, 5'b00111, 5'd20, 1, 3, g5(19), 0, 0, 14, 0);
    add(0, 1, 0, 5'b00111, 5'd20, 1, 4, g5(20), 0, 0, 15, 0);
    add(0, 1, 0, 5'b00111, 5'd20, 1, 5, 5'b11111, 1, 1, 16, 0);
    // Reset from full drops everything.
    add(1, 1, 0, 5'b00111, 5'd20, 0, 0, 0, 0, 0, 0, 0);

    drive(1, 1, 0, 5'd0, 5'd12);
    @(negedge w_clk);
    for (int i = 0; i < n_vecs; i++) begin
      drive(vecs[i].rst, vecs[i].inc, vecs[i].clr, vecs[i].rg, vecs[i].thresh);
      #1;
      check("accept", i, 32'(w_accept), 32'(vecs[i].exp_accept));
      @(posedge w_clk);
      #1;
      check("addr",  i, 32'(w_addr),  32'(vecs[i].exp_addr));
      check("gray",  i, 32'(w_gray),  32'(vecs[i].exp_gray));
      check("full",  i, 32'(w_full),  32'(vecs[i].exp_full));
      check("afull", i, 32'(w_afull), 32'(vecs[i].exp_afull));
      check("level", i, 32'(w_level), 32'(vecs[i].exp_level));
      check("ovf",   i, 32'(w_ovf),   32'(vecs[i].exp_ovf));
      @(negedge w_clk);
    end

    // 40 writes with a model reader holding the level at or below 8, across the 31->0 rollover.
    wc = 0;
    rc = 0;
    prev_gray = w_gray;
    for (int i = 0; i < 40; i++) begin
      if (wc - rc >= 8) rc++;
      drive(0, 1, 0, g5(rc), 5'd0);
      #1;
      check("walk_accept", i, 32'(w_accept), 1);
      @(posedge w_clk);
      #1;
      wc++;
      check("walk_level", i, 32'(w_level), 32'(5'(wc - rc)));
      check("walk_gray",  i, 32'(w_gray),  32'(g5(wc)));
      check("walk_hd1",   i, $countones(w_gray ^ prev_gray), 1);
      check("walk_addr",  i, 32'(w_addr),  32'(wc % 16));
      check("walk_full",  i, 32'(w_full),  0);
      prev_gray = w_gray;
      @(negedge w_clk);
    end

    // Reset, seven writes, then reset again mid-burst with a write pending.
    drive(1, 0, 0, 5'd0, 5'd12);
    @(posedge w_clk);
    @(negedge w_clk);
    for (int i = 0; i < 7; i++) begin
      drive(0, 1, 0, 5'd0, 5'd12);
      @(posedge w_clk);
      @(negedge w_clk);
    end
    check("pre_rst_addr", 0, 32'(w_addr), 7);
    drive(1, 1, 0, 5'd0, 5'd12);
    #1;
    check("mid_rst_accept", 0, 32'(w_accept), 0);
    @(posedge w_clk);
    #1;
    check_all_zero("mid_rst", 0);
    @(negedge w_clk);
    drive(0, 0, 0, 5'd0, 5'd12);
    @(negedge w_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
